// File: rtl/week_5_pkg.sv
// Shared types and default sizes for the week-5 decoder FIFO.
package week_5_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef logic [1:0] code_t;
  typedef logic [3:0] onehot_t;
endpackage

// File: rtl/week_5_decoder_2to4.sv
// 2-to-4 one-hot decoder; the inverse of the week-4 4-to-2 encoder.
module week_5_decoder_2to4
  import week_5_pkg::*;
(
  input  code_t   in,
  output onehot_t out
);
  // Bit k of the result is set for code k.
  assign out = onehot_t'(4'b0001 << in);
endmodule

// File: rtl/week_5_decoder_fifo.sv
// Small FIFO of 2-bit codes presenting the head entry one-hot decoded,
// with saturating per-code counters that count delivered entries.
module week_5_decoder_fifo
  import week_5_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               in_code,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               out_onehot,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     cnt_clr,
  output logic [4*CNT_W-1:0]       hit_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  code_t            mem [DEPTH];
  logic [AW-1:0]    head, tail;
  logic [LW-1:0]    lvl;
  logic             push, pop;
  code_t            head_code;
  onehot_t          dec;

  // Full blocks pushes outright, even when a pop frees a slot this cycle.
  assign in_ready  = (lvl != LW'(DEPTH)) && !rst;
  assign out_valid = (lvl != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = lvl;
  assign head_code = mem[head];

  week_5_decoder_2to4 u_dec (
    .in  (head_code),
    .out (dec)
  );

  // Stale storage behind an empty buffer must never leak onto the output.
  assign out_onehot = out_valid ? dec : '0;

  // Storage carries no reset; only entries below level are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_code;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      lvl  <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_cnt
    logic [CNT_W-1:0] c;

    // Count pops of code k, sticking at all-ones; clear beats increment.
    always_ff @(posedge clk) begin
      if (rst || cnt_clr)
        c <= '0;
      else if (pop && head_code == code_t'(k) && c != '1)
        c <= c + CNT_W'(1);
    end

    assign hit_count[k*CNT_W +: CNT_W] = c;
  end
endmodule

// File: tb/tb_week_5_decoder_fifo.sv
// Randomized and directed checks of week_5_decoder_fifo against a queue model.
module tb_week_5_decoder_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                  clk;
  logic                  rst;
  logic [1:0]            in_code;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            out_onehot;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            level;
  logic                  cnt_clr;
  logic [4*CNT_W-1:0]    hit_count;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of codes and plain integer hit counts.
  logic [1:0]  q[$];
  int unsigned cnt[4];

  week_5_decoder_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .cnt_clr    (cnt_clr),
    .hit_count  (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [1:0] c;
    bit do_push, do_pop;
    if (rst) begin
      q.delete();
      for (int k = 0; k < 4; k++) cnt[k] = 0;
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) begin
        c = q.pop_front();
        if (cnt[c] < CMAX) cnt[c]++;
      end
      if (cnt_clr)
        for (int k = 0; k < 4; k++) cnt[k] = 0;
      if (do_push) q.push_back(in_code);
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_oh;
    exp_oh = (q.size() > 0) ? (4'b0001 << q[0]) : 4'b0000;
    chk("level",      64'(level),      64'(q.size()));
    chk("out_valid",  64'(out_valid),  64'(q.size() > 0));
    chk("out_onehot", 64'(out_onehot), 64'(exp_oh));
    chk("in_ready",   64'(in_ready),   64'((q.size() != DEPTH) && !rst));
    for (int k = 0; k < 4; k++)
      chk($sformatf("hit_count[%0d]", k), 64'(hit_count[k*CNT_W +: CNT_W]), 64'(cnt[k]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_code   = 2'b00;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    step();

    // Reset then idle.
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_hits",  64'(hit_count), 64'd0);

    // Fill with 00,01,10,11 while the consumer stalls, then drain.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code  = 2'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("full_level", 64'(level),    64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("stall_oh",   64'(out_onehot), 64'b0001);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_oh", 64'(out_onehot), 64'(4'b0001 << i));
      step();
    end
    out_ready = 1'b0;
    chk("drain_hits", 64'(hit_count), 64'h01010101);

    // Full with push and pop on the same edge: only the pop happens.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code  = 2'($urandom_range(3));
      step();
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    chk("full_pushpop_level", 64'(level), 64'd3);
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) step();
    idle_inputs();

    // Stream 11 for 300 cycles; code 3 counter saturates.
    cnt_clr = 1'b1;
    step();
    cnt_clr   = 1'b0;
    in_valid  = 1'b1;
    in_code   = 2'b11;
    out_ready = 1'b1;
    repeat (300) step();
    chk("sat_hit3",   64'(hit_count[3*CNT_W +: CNT_W]), 64'(CMAX));
    chk("sat_others", 64'(hit_count[3*CNT_W-1:0]),      64'd0);
    in_valid = 1'b0;
    step();
    idle_inputs();

    // Clear on the same edge as a pop of 10.
    in_valid = 1'b1;
    in_code  = 2'b10;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    step();
    chk("clr_vs_pop", 64'(hit_count), 64'd0);
    idle_inputs();

    // Reset mid-stream with two entries buffered.
    in_valid = 1'b1;
    in_code  = 2'b01;
    step();
    in_code  = 2'b10;
    step();
    in_valid = 1'b0;
    chk("pre_rst_level", 64'(level), 64'd2);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    step();
    chk("rst_level", 64'(level),     64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic, including occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_code   = 2'($urandom_range(3));
      out_ready = ($urandom_range(2) != 0);
      cnt_clr   = ($urandom_range(63) == 0);
      rst       = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/week_5_decoder_fifo.md
WEEK_5_DECODER_FIFO -- requirements
Module: week_5_decoder_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered 2-bit codes (power of two, at least 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of each per-code hit counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_code, input, 2 bits: binary code to decode (00..11).
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_code is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_code this cycle.
REQ-008 The block SHALL have port out_onehot, output, 4 bits: one-hot decode of the head code.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_onehot holds a decoded entry.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_onehot this cycle.
REQ-011 The block SHALL have port level, output, clog2(DEPTH)+1 bits: current number of stored entries.
REQ-012 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of all hit counters.
REQ-013 The block SHALL have port hit_count, output, 4*CNT_W bits: saturating hit counters; slice [k*CNT_W +: CNT_W] counts code k.

Function
REQ-014 The block SHALL perform a push when in_valid && in_ready at a rising edge, writing in_code at the tail and advancing the tail pointer modulo DEPTH.
REQ-015 The block SHALL perform a pop when out_valid && out_ready at a rising edge, advancing the head pointer modulo DEPTH.
REQ-016 The block SHALL drive in_ready = (level != DEPTH) && !rst; there is no pass-through when full, even if a pop occurs in the same cycle.
REQ-017 The block SHALL drive out_valid = (level != 0), registered-state driven only, with no combinational path from in_valid.
REQ-018 The block SHALL drive out_onehot = 4'b0001 << head_code when out_valid is 1, and 4'b0000 when out_valid is 0.
REQ-019 The block SHALL decode codes as: 00->0001, 01->0010, 10->0100, 11->1000.
REQ-020 The block SHALL have a latency of one cycle: a code pushed at edge N into an empty buffer appears on out_onehot with out_valid=1 immediately after edge N.
REQ-021 The block SHALL update level as: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (allowed when 0 < level < DEPTH) or on neither.
REQ-022 The block SHALL ignore pops when empty and pushes when full; pointers and level remain unchanged.
REQ-023 The block SHALL deliver entries strictly in FIFO order.
REQ-024 The block SHALL keep out_onehot and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 On each pop of code k, the block SHALL increment hit counter k by 1, holding it at 2^CNT_W-1 once reached (saturation; no wrap).
REQ-026 When cnt_clr=1, all counters SHALL be 0 after the edge; cnt_clr takes priority over a simultaneous pop increment.
REQ-027 Buffer contents beyond the valid entries SHALL NOT affect any output.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL set the head pointer, tail pointer and level to 0 and all hit counters to 0.
REQ-029 While rst=1, the block SHALL drive in_ready=0; after reset, out_valid=0 and out_onehot=4'b0000.
REQ-030 Reset asserted mid-stream SHALL discard all buffered entries; no entry is delivered after rst, and rst overrides any simultaneous push, pop or cnt_clr.
REQ-031 The storage array SHALL NOT require a reset.

Structure
REQ-032 The shared package week_5_pkg SHALL hold the DEPTH and CNT_W defaults, a 2-bit code typedef and a 4-bit one-hot typedef.
REQ-033 The one-hot decode SHALL be implemented in the combinational sub-module week_5_decoder_2to4 (in[1:0] -> out[3:0]), which is the inverse of the week-4 4-to-2 encoder.
REQ-034 The FIFO, handshake and counters SHALL reside in week_5_decoder_fifo.

Verification
REQ-035 Reset then idle -> the bench SHALL see out_valid=0, out_onehot=0000, level=0, in_ready=1 and all hit_count slices 0.
REQ-036 Push 00,01,10,11 with out_ready=0, then drain with out_ready=1 -> the bench SHALL see level reach 4, in_ready=0, then outputs 0001, 0010, 0100, 1000 in order, and each hit_count slice equal to 1.
REQ-037 Full buffer with in_valid=1 and out_ready=1 on the same cycle -> the bench SHALL see the push refused and the pop performed, leaving level=3.
REQ-038 Continuous streaming of 11 with both in_valid and out_ready held at 1 for 300 cycles -> the bench SHALL see hit_count[3] saturate at 255 while the other slices stay 0.
REQ-039 cnt_clr asserted on the same cycle as a pop of 10 -> the bench SHALL see every hit_count slice equal to 0 after the edge.
REQ-040 rst asserted with level=2 -> the bench SHALL see level=0 and out_valid=0 on the next cycle, and the discarded codes never appear on the output.
